// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receive deserializer: 2-FF rx synchroniser, start-bit qualification, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop, flagged on parity_err.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_clr,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_done,
    output logic       busy,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd5,
`endif
        BREAK  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                rx_m;
    logic                rx_s;
    logic [CNT_W-1:0]    cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   shift;
    logic                tick;
    logic                half;
    logic                sample;
    logic                good_stop;
    logic                ferr_set;
    logic                perr_set;

    assign tick = (cnt == TICK_CNT);
    assign half = (cnt == HALF_CNT);

    // Two-stage synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        good_stop  = 1'b0;
        ferr_set   = 1'b0;
        perr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (half) state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    sample = 1'b1;
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    perr_set   = (rx_s != (^shift));
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        good_stop  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Baud counter restarts on every state change and wraps each bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (state_next != state || state == IDLE || tick) cnt <= '0;
            else                                               cnt <= cnt + CNT_W'(1);
            if (state != DATA) bit_idx <= '0;
            else if (sample)   bit_idx <= bit_idx + BIT_W'(1);
            if (sample) shift <= {rx_s, shift[DATA_W-1:1]};
        end
    end

    // Byte is handed over during the rx_done cycle; a coincident rx_clr loses to the load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_ready   <= 1'b0;
            rx_done    <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_done <= good_stop;
            busy    <= (state_next != IDLE);
            if (rx_done) begin
                rx_data  <= shift;
                rx_ready <= 1'b1;
            end else if (rx_clr) begin
                rx_ready <= 1'b0;
            end
            if (rx_done && rx_ready && !rx_clr) overrun <= 1'b1;
            else if (rx_clr)                    overrun <= 1'b0;
            if (ferr_set)    frame_err <= 1'b1;
            else if (rx_clr) frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (perr_set)    parity_err <= 1'b1;
            else if (rx_clr) parity_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clocks per bit.
// Covers good frames, start glitch, framing error with held-low line, overrun, clear/load race, mid-frame reset.
module tb_uart_rx_deserializer;

    localparam int unsigned C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned LAT = 2 + C / 2 + 10 * C + 1;
`else
    localparam int unsigned LAT = 2 + C / 2 + 9 * C + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx_clr;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_done;
    logic       busy;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    int vec_cnt   = 0;
    int err_cnt   = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int done_cnt  = 0;
    int done_base = 0;
    logic found;

    uart_rx_deserializer #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_clr    (rx_clr),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_done   (rx_done),
        .busy      (busy),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rx_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; the line is left at the stop-bit level afterwards
    task automatic send_byte(input logic [7:0] d, input logic stop_b);
        @(posedge clk);
        #1 rx = 1'b0;
        start_cyc = cyc;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (C) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx = (^d) ^ par_flip;
        repeat (C) @(posedge clk);
`endif
        #1 rx = stop_b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output logic hit);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (rx_done === 1'b1) hit = 1'b1;
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 rx_clr = 1'b1;
        @(posedge clk);
        #1 rx_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(rx_data),   32'h0);
        check({tag, "_ready"}, 32'(rx_ready),  32'h0);
        check({tag, "_done"},  32'(rx_done),   32'h0);
        check({tag, "_busy"},  32'(busy),      32'h0);
        check({tag, "_ferr"},  32'(frame_err), 32'h0);
        check({tag, "_ovr"},   32'(overrun),   32'h0);
`ifdef UART_RX_PARITY_EN
        check({tag, "_perr"},  32'(parity_err), 32'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        rx     = 1'b1;
        rx_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // Good frame 0xA5: latency, single-cycle strobe, data handover
        fork
            send_byte(8'hA5, 1'b1);
            begin
                wait_done(found);
                check("a5_done_seen", 32'(found), 32'h1);
                check("a5_latency", 32'(cyc - start_cyc), 32'(LAT));
                @(negedge clk);
                check("a5_done_width", 32'(rx_done), 32'h0);
                check("a5_data", 32'(rx_data), 32'hA5);
                check("a5_ready", 32'(rx_ready), 32'h1);
            end
        join
        idle(4);
        @(negedge clk);
        check("a5_busy", 32'(busy), 32'h0);
        check("a5_ferr", 32'(frame_err), 32'h0);
        check("a5_done_cnt", 32'(done_cnt), 32'h1);
        pulse_clr();
        @(negedge clk);
        check("clr_ready", 32'(rx_ready), 32'h0);

        // Start-bit glitch of 4 cycles is rejected at the half tick
        done_base = done_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        idle(10);
        @(negedge clk);
        check("glitch_busy_lo", 32'(busy), 32'h0);
        check("glitch_ready", 32'(rx_ready), 32'h0);
        check("glitch_no_done", 32'(done_cnt), 32'(done_base));
        send_byte(8'h3C, 1'b1);
        idle(4);
        @(negedge clk);
        check("3c_data", 32'(rx_data), 32'h3C);
        check("3c_done_cnt", 32'(done_cnt), 32'(done_base + 1));
        pulse_clr();

        // Framing error, then line held low must not re-trigger
        done_base = done_cnt;
        send_byte(8'h55, 1'b0);
        idle(40);
        @(negedge clk);
        check("ferr_set", 32'(frame_err), 32'h1);
        check("ferr_ready", 32'(rx_ready), 32'h0);
        check("ferr_busy_break", 32'(busy), 32'h1);
        check("ferr_data_kept", 32'(rx_data), 32'h3C);
        @(posedge clk);
        #1 rx = 1'b1;
        idle(6);
        @(negedge clk);
        check("ferr_busy_lo", 32'(busy), 32'h0);
        check("ferr_no_done", 32'(done_cnt), 32'(done_base));
        send_byte(8'h0F, 1'b1);
        idle(4);
        @(negedge clk);
        check("0f_data", 32'(rx_data), 32'h0F);
        check("0f_ready", 32'(rx_ready), 32'h1);
        check("0f_ferr_sticky", 32'(frame_err), 32'h1);
        pulse_clr();
        @(negedge clk);
        check("ferr_cleared", 32'(frame_err), 32'h0);

        // Overrun without acknowledge
        send_byte(8'h11, 1'b1);
        idle(4);
        send_byte(8'h22, 1'b1);
        idle(4);
        @(negedge clk);
        check("ovr_set", 32'(overrun), 32'h1);
        check("ovr_data", 32'(rx_data), 32'h22);
        pulse_clr();
        @(negedge clk);
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Acknowledge coinciding with the second byte's handover
        send_byte(8'h11, 1'b1);
        idle(4);
        fork
            send_byte(8'h22, 1'b1);
            begin
                wait_done(found);
                check("race_done_seen", 32'(found), 32'h1);
                rx_clr = 1'b1;
                @(posedge clk);
                #1 rx_clr = 1'b0;
            end
        join
        idle(4);
        @(negedge clk);
        check("race_ovr", 32'(overrun), 32'h0);
        check("race_ready", 32'(rx_ready), 32'h1);
        check("race_data", 32'(rx_data), 32'h22);

        // Reset during data bit 4 of 0xFF discards the partial byte
        done_base = done_cnt;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (90) @(posedge clk);
                #1 rst_n = 1'b0;
                @(negedge clk);
                check_all_zero("midrst");
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        idle(4);
        send_byte(8'h81, 1'b1);
        idle(4);
        @(negedge clk);
        check("81_data", 32'(rx_data), 32'h81);
        check("81_ready", 32'(rx_ready), 32'h1);
        check("81_one_done", 32'(done_cnt), 32'(done_base + 1));
        pulse_clr();

`ifdef UART_RX_PARITY_EN
        // Even parity: correct bit, then inverted bit
        par_flip = 1'b0;
        send_byte(8'h03, 1'b1);
        idle(4);
        @(negedge clk);
        check("par_ok_perr", 32'(parity_err), 32'h0);
        check("par_ok_data", 32'(rx_data), 32'h03);
        pulse_clr();
        par_flip = 1'b1;
        send_byte(8'h03, 1'b1);
        idle(4);
        @(negedge clk);
        check("par_bad_perr", 32'(parity_err), 32'h1);
        check("par_bad_data", 32'(rx_data), 32'h03);
        check("par_bad_ready", 32'(rx_ready), 32'h1);
        par_flip = 1'b0;
        pulse_clr();
        @(negedge clk);
        check("par_cleared", 32'(parity_err), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Serial receive front end that sits directly upstream of the UART IP's register interface in the RISC-V SoC.
- Synchronises the asynchronous rx pin and detects start bits.
- Samples 8N1 frames at the bit centre and presents each completed byte with a ready flag, a one-cycle done strobe and sticky error flags.
- The UART IP reads rx_data on a processor load and acknowledges with rx_clr.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); must be >= 4.
- CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_clr  input  1  one-cycle acknowledge from the UART IP; clears rx_ready and all error flags.
- rx_data  output  8  last good byte received; holds until overwritten.
- rx_ready  output  1  unread byte available (sticky).
- rx_done  output  1  one-cycle pulse per good byte.
- busy  output  1  high in every state except IDLE.
- frame_err  output  1  sticky; stop bit sampled as 0.
- overrun  output  1  sticky; new byte arrived while rx_ready was still 1.

Behaviour:
- Reset values:
  - All outputs 0; rx_data = 8'h00.
  - Synchroniser stages = 1; state = IDLE; baud counter and bit index = 0.
- Synchroniser: 2-FF chain, rx -> rx_s. All decisions use rx_s, giving 2 cycles of input latency.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within a bit and is cleared on every state change.
  - A "tick" is counter == CLKS_PER_BIT-1; a "half tick" is counter == CLKS_PER_BIT/2-1 (integer division).
- State machine:
  - IDLE:
    - rx_s == 0 -> START, counter cleared.
  - START:
    - At the half tick, rx_s == 0 -> DATA, counter and bit index cleared.
    - At the half tick, rx_s == 1 -> IDLE (glitch rejected; no flags change).
  - DATA:
    - On each tick, shift rx_s into the shift register LSB first and increment the bit index.
    - After the 8th bit -> STOP (or PARITY with the macro).
  - STOP:
    - On the tick with rx_s == 1 (good frame), in the next cycle:
      - rx_data <= shift register; rx_ready <= 1; rx_done = 1 for exactly 1 cycle.
      - If rx_ready was already 1 and rx_clr is not asserted that cycle, overrun <= 1.
      - Next state IDLE.
    - On the tick with rx_s == 0 (bad frame):
      - frame_err <= 1.
      - rx_data, rx_ready and rx_done are unchanged.
      - Next state BREAK.
  - BREAK:
    - Wait for rx_s == 1, then -> IDLE. A held-low line never re-triggers START.
- Sampling points: data bits are sampled in the middle of each bit (START consumed half a bit).
- rx_clr:
  - Clears rx_ready, frame_err, overrun (and parity_err) in any state.
  - Does not affect the state machine or rx_data.
- rx_clr in the same cycle as a byte load:
  - The load wins: rx_ready = 1 and overrun is not set.
  - frame_err and overrun are still cleared.
- Frame latency: rx_done fires 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the start-bit falling edge on rx (±1 for synchroniser phase).
- Reset asserted mid-frame: immediate return to reset values. A partial byte is discarded and never reported.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP and output port parity_err (1 bit, sticky, cleared by rx_clr and reset).
  - On the PARITY tick, the sampled bit is compared with even parity (XOR of the 8 data bits).
  - On mismatch: parity_err <= 1; the byte is still loaded on a good stop bit.
  - Frame latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity_err port; frame is 8N1 as above.

Test Plan:
- CLKS_PER_BIT=16; send 0xA5 with stop=1 -> rx_data=0xA5, rx_ready=1, rx_done high exactly 1 cycle about 155 cycles after the start edge, busy back to 0, frame_err=0.
- rx low for 4 cycles then high -> START aborts at the half tick; busy drops after about 10 cycles; rx_ready and rx_done stay 0; following byte 0x3C received correctly.
- Send 0x55 with stop=0, hold rx low 40 cycles, then send 0x0F -> frame_err=1, rx_ready=0 after the first frame, no re-trigger during the low hold; rx_data=0x0F and rx_ready=1 after the second frame.
- Send 0x11 then 0x22 with no rx_clr -> overrun=1, rx_data=0x22. Repeat with rx_clr pulsed in the same cycle as the second rx_done -> overrun=0, rx_ready=1.
- Assert rst_n low during data bit 4 of 0xFF, release, send 0x81 -> all outputs 0 during reset; only 0x81 reported; exactly one rx_done.
- With UART_RX_PARITY_EN: send 0x03 with parity bit 0 -> parity_err=0. Send 0x03 with parity bit 1 -> parity_err=1, rx_data=0x03, rx_ready=1.
